// File: rtl/idma_irq_pkg.sv
// Shared definitions for the iDMA interrupt coalescer: register map offsets,
// pending-bit positions, configuration view and FSM state encodings.
package idma_irq_pkg;

    localparam int unsigned CH_STRIDE = 32;

    localparam logic [4:0] PENDING_OFF = 5'h00;
    localparam logic [4:0] ENABLE_OFF  = 5'h08;
    localparam logic [4:0] CFG_OFF     = 5'h10;
    localparam logic [4:0] COUNT_OFF   = 5'h18;

    localparam int unsigned PEND_DONE_BIT = 0;
    localparam int unsigned PEND_ERR_BIT  = 1;

    // Layout of a CFG write word: THRESH in the low half, TIMEOUT in the high half.
    typedef struct packed {
        logic [31:0] timeout;
        logic [31:0] thresh;
    } chan_cfg_t;

    typedef enum logic {
        CH_EMPTY,
        CH_ACCUM
    } chan_state_t;

    typedef enum logic {
        BUS_IDLE,
        BUS_RESP
    } bus_state_t;

endpackage

// File: rtl/idma_irq_chan.sv
// One coalescing channel: completion counter with threshold, timeout timer,
// W1C pending flags, enable mask and the registered interrupt line.
module idma_irq_chan
    import idma_irq_pkg::*;
#(
    parameter int unsigned CountWidth = 8,
    parameter int unsigned TimerWidth = 16
) (
    input  logic                  i_clk,
    input  logic                  i_srst,
    input  logic                  i_done,
    input  logic                  i_err,
    input  logic [1:0]            i_pend_w1c,
    input  logic                  i_enable_we,
    input  logic [1:0]            i_enable_wdata,
    input  logic                  i_cfg_we,
    input  logic [CountWidth-1:0] i_cfg_thresh,
    input  logic [TimerWidth-1:0] i_cfg_timeout,
    output logic [1:0]            o_pending,
    output logic [1:0]            o_enable,
    output logic [CountWidth-1:0] o_thresh,
    output logic [TimerWidth-1:0] o_timeout,
    output logic [CountWidth-1:0] o_count,
    output logic                  o_irq
);

    chan_state_t           r_state;
    logic [CountWidth-1:0] r_count;
    logic [CountWidth-1:0] r_thresh;
    logic [TimerWidth-1:0] r_timer;
    logic [TimerWidth-1:0] r_timeout;
    logic [1:0]            r_pending;
    logic [1:0]            r_enable;
    logic                  r_irq;

    logic [CountWidth-1:0] w_count_inc;
    logic [CountWidth-1:0] w_eff_thresh;
    logic                  w_thresh_hit;
    logic                  w_timeout_hit;
    logic                  w_fire;

    assign w_count_inc  = (i_done && (r_count != '1)) ? r_count + 1'b1 : r_count;
    assign w_eff_thresh = (r_thresh == '0) ? CountWidth'(1) : r_thresh;

    // Comparing every cycle (not only on done) also catches a THRESH lowered
    // below the current count by a CFG write.
    assign w_thresh_hit  = (w_count_inc >= w_eff_thresh);
    assign w_timeout_hit = (r_state == CH_ACCUM) && (r_timeout != '0) &&
                           (r_timer >= r_timeout - 1'b1);
    assign w_fire        = w_thresh_hit | w_timeout_hit;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_state   <= CH_EMPTY;
            r_count   <= '0;
            r_thresh  <= CountWidth'(1);
            r_timer   <= '0;
            r_timeout <= '0;
            r_pending <= '0;
            r_enable  <= '0;
            r_irq     <= 1'b0;
        end else begin
            // Hardware sets take priority over a same-cycle W1C.
            r_pending[PEND_DONE_BIT] <= w_fire |
                (r_pending[PEND_DONE_BIT] & ~i_pend_w1c[PEND_DONE_BIT]);
            r_pending[PEND_ERR_BIT]  <= i_err |
                (r_pending[PEND_ERR_BIT] & ~i_pend_w1c[PEND_ERR_BIT]);

            if (i_enable_we) begin
                r_enable <= i_enable_wdata;
            end
            if (i_cfg_we) begin
                r_thresh  <= i_cfg_thresh;
                r_timeout <= i_cfg_timeout;
            end

            r_irq <= |(r_pending & r_enable);

            if (w_fire) begin
                r_count <= '0;
                r_timer <= '0;
                r_state <= CH_EMPTY;
            end else begin
                r_count <= w_count_inc;
                r_state <= (w_count_inc != '0) ? CH_ACCUM : CH_EMPTY;
                r_timer <= ((r_state == CH_ACCUM) && (r_timeout != '0)) ?
                           r_timer + 1'b1 : '0;
            end
        end
    end

    assign o_pending = r_pending;
    assign o_enable  = r_enable;
    assign o_thresh  = r_thresh;
    assign o_timeout = r_timeout;
    assign o_count   = r_count;
    assign o_irq     = r_irq;

endmodule

// File: rtl/idma_irq_coalescer.sv
// Multi-channel iDMA interrupt coalescer: register-bus slave with address
// decode and one coalescing channel per DMA channel.
module idma_irq_coalescer
    import idma_irq_pkg::*;
#(
    parameter int unsigned NumChannels  = 4,
    parameter int unsigned CountWidth   = 8,
    parameter int unsigned TimerWidth   = 16,
    parameter int unsigned RegAddrWidth = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NumChannels-1:0]  done_i,
    input  logic [NumChannels-1:0]  err_i,
    input  logic                    reg_valid_i,
    input  logic                    reg_write_i,
    input  logic [RegAddrWidth-1:0] reg_addr_i,
    input  logic [63:0]             reg_wdata_i,
    output logic                    reg_ready_o,
    output logic [63:0]             reg_rdata_o,
    output logic                    reg_error_o,
    output logic [NumChannels-1:0]  irq_o
);

    localparam int unsigned MapBytes = NumChannels * CH_STRIDE;
    localparam int unsigned ChIdxW   = RegAddrWidth - 5;

    bus_state_t  r_state;
    logic        r_ready;
    logic [63:0] r_rdata;
    logic        r_error;

    logic                   w_misaligned;
    logic                   w_unmapped;
    logic                   w_addr_err;
    logic                   w_wr_ok;
    logic [ChIdxW-1:0]      w_ch_idx;
    logic [4:0]             w_off;
    chan_cfg_t              w_cfg_wr;
    logic [NumChannels-1:0] w_sel;
    logic [63:0]            w_rdata;
    logic                   w_unused_wdata;

    logic [1:0]            w_pend_w1c [NumChannels];
    logic [1:0]            w_pend     [NumChannels];
    logic [1:0]            w_enable   [NumChannels];
    logic [CountWidth-1:0] w_thresh   [NumChannels];
    logic [TimerWidth-1:0] w_timeout  [NumChannels];
    logic [CountWidth-1:0] w_count    [NumChannels];

    assign w_misaligned = |reg_addr_i[2:0];
    assign w_unmapped   = (32'(reg_addr_i) >= MapBytes);
    assign w_addr_err   = w_misaligned | w_unmapped;
    assign w_ch_idx     = reg_addr_i[RegAddrWidth-1:5];
    assign w_off        = reg_addr_i[4:0];
    assign w_cfg_wr     = chan_cfg_t'(reg_wdata_i);
    assign w_wr_ok      = (r_state == BUS_IDLE) && reg_valid_i && reg_write_i && !w_addr_err;

    // Only the low bits of most write words are stored.
    assign w_unused_wdata = ^{reg_wdata_i, w_cfg_wr};

    generate
        for (genvar gi = 0; gi < NumChannels; gi++) begin : g_chan
            logic w_en_we;
            logic w_cfg_we;

            assign w_sel[gi]      = (w_ch_idx == ChIdxW'(gi));
            assign w_pend_w1c[gi] = (w_wr_ok && w_sel[gi] && (w_off == PENDING_OFF)) ?
                                    reg_wdata_i[1:0] : 2'b00;
            assign w_en_we        = w_wr_ok && w_sel[gi] && (w_off == ENABLE_OFF);
            assign w_cfg_we       = w_wr_ok && w_sel[gi] && (w_off == CFG_OFF);

            idma_irq_chan #(
                .CountWidth (CountWidth),
                .TimerWidth (TimerWidth)
            ) u_chan (
                .i_clk          (clk_i),
                .i_srst         (rst_i),
                .i_done         (done_i[gi]),
                .i_err          (err_i[gi]),
                .i_pend_w1c     (w_pend_w1c[gi]),
                .i_enable_we    (w_en_we),
                .i_enable_wdata (reg_wdata_i[1:0]),
                .i_cfg_we       (w_cfg_we),
                .i_cfg_thresh   (w_cfg_wr.thresh[CountWidth-1:0]),
                .i_cfg_timeout  (w_cfg_wr.timeout[TimerWidth-1:0]),
                .o_pending      (w_pend[gi]),
                .o_enable       (w_enable[gi]),
                .o_thresh       (w_thresh[gi]),
                .o_timeout      (w_timeout[gi]),
                .o_count        (w_count[gi]),
                .o_irq          (irq_o[gi])
            );
        end
    endgenerate

    always_comb begin
        w_rdata = '0;
        for (int c = 0; c < NumChannels; c++) begin
            if (w_sel[c]) begin
                case (w_off)
                    PENDING_OFF: w_rdata = 64'(w_pend[c]);
                    ENABLE_OFF:  w_rdata = 64'(w_enable[c]);
                    CFG_OFF: begin
                        w_rdata                    = '0;
                        w_rdata[CountWidth-1:0]    = w_thresh[c];
                        w_rdata[32 +: TimerWidth]  = w_timeout[c];
                    end
                    COUNT_OFF:   w_rdata = 64'(w_count[c]);
                    default:     w_rdata = '0;
                endcase
            end
        end
    end

    // Requests seen while in RESP are ignored; the master keeps valid high until ready.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= BUS_IDLE;
            r_ready <= 1'b0;
            r_rdata <= '0;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                BUS_IDLE: begin
                    if (reg_valid_i) begin
                        r_state <= BUS_RESP;
                        r_ready <= 1'b1;
                        r_error <= w_addr_err;
                        r_rdata <= (!reg_write_i && !w_addr_err) ? w_rdata : '0;
                    end
                end
                BUS_RESP: begin
                    r_state <= BUS_IDLE;
                    r_ready <= 1'b0;
                    r_rdata <= '0;
                    r_error <= 1'b0;
                end
                default: r_state <= BUS_IDLE;
            endcase
        end
    end

    assign reg_ready_o = r_ready;
    assign reg_rdata_o = r_rdata;
    assign reg_error_o = r_error;

endmodule

// File: tb/tb_idma_irq_coalescer.sv
// Directed bench for idma_irq_coalescer: register-map table plus hand-timed
// sequences for threshold, timeout, W1C races and reset during a request.
module tb_idma_irq_coalescer;

    localparam int NCH = 4;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [NCH-1:0]  done_i;
    logic [NCH-1:0]  err_i;
    logic            reg_valid_i;
    logic            reg_write_i;
    logic [7:0]      reg_addr_i;
    logic [63:0]     reg_wdata_i;
    logic            reg_ready_o;
    logic [63:0]     reg_rdata_o;
    logic            reg_error_o;
    logic [NCH-1:0]  irq_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];

    idma_irq_coalescer #(
        .NumChannels  (NCH),
        .CountWidth   (8),
        .TimerWidth   (16),
        .RegAddrWidth (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .done_i      (done_i),
        .err_i       (err_i),
        .reg_valid_i (reg_valid_i),
        .reg_write_i (reg_write_i),
        .reg_addr_i  (reg_addr_i),
        .reg_wdata_i (reg_wdata_i),
        .reg_ready_o (reg_ready_o),
        .reg_rdata_o (reg_rdata_o),
        .reg_error_o (reg_error_o),
        .irq_o       (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Starts just after an edge; the next edge samples the request.
    task automatic bus(input bit wr, input logic [7:0] addr, input logic [63:0] wdata,
                       output logic [63:0] rdata, output logic err);
        bit got;
        got   = 1'b0;
        rdata = '0;
        err   = 1'b0;
        reg_valid_i = 1'b1;
        reg_write_i = wr;
        reg_addr_i  = addr;
        reg_wdata_i = wdata;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk_i);
            #1;
            if (reg_ready_o) begin
                got   = 1'b1;
                rdata = reg_rdata_o;
                err   = reg_error_o;
            end
        end
        reg_valid_i = 1'b0;
        reg_write_i = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL bus_ready_timeout: got no ready expected ready within 8 cycles addr=0x%02h", addr);
        end
        @(posedge clk_i);
        #1;
        check("ready_one_cycle", 64'(reg_ready_o), 64'd0);
        $display("txn %s addr=0x%02h wdata=0x%016h rdata=0x%016h err=%0d",
                 wr ? "WR" : "RD", addr, wdata, rdata, err);
    endtask

    task automatic rd_check(input string name, input logic [7:0] addr, input logic [63:0] exp);
        logic [63:0] rd;
        logic        er;
        bus(1'b0, addr, 64'd0, rd, er);
        check(name, rd, exp);
    endtask

    task automatic wr(input logic [7:0] addr, input logic [63:0] data);
        logic [63:0] rd;
        logic        er;
        bus(1'b1, addr, data, rd, er);
    endtask

    task automatic pulse_done(input int ch);
        done_i[ch] = 1'b1;
        @(posedge clk_i);
        #1;
        done_i[ch] = 1'b0;
    endtask

    initial begin
        logic [63:0] rd;
        logic        er;

        rst_i       = 1'b1;
        done_i      = '0;
        err_i       = '0;
        reg_valid_i = 1'b0;
        reg_write_i = 1'b0;
        reg_addr_i  = '0;
        reg_wdata_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_ready", 64'(reg_ready_o), 64'd0);
        check("rst_rdata", reg_rdata_o, 64'd0);
        check("rst_error", 64'(reg_error_o), 64'd0);
        check("rst_irq", 64'(irq_o), 64'd0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Register-map table: reset values, decode errors, RO and masking behaviour.
        for (int c = 0; c < NCH; c++) begin
            vecs.push_back('{1'b0, 8'(c * 32 + 8'h00), 64'd0, 64'd0, 1'b0});
            vecs.push_back('{1'b0, 8'(c * 32 + 8'h08), 64'd0, 64'd0, 1'b0});
            vecs.push_back('{1'b0, 8'(c * 32 + 8'h10), 64'd0, 64'd1, 1'b0});
            vecs.push_back('{1'b0, 8'(c * 32 + 8'h18), 64'd0, 64'd0, 1'b0});
        end
        vecs.push_back('{1'b0, 8'h88, 64'd0, 64'd0, 1'b1});
        vecs.push_back('{1'b0, 8'h04, 64'd0, 64'd0, 1'b1});
        vecs.push_back('{1'b0, 8'h80, 64'd0, 64'd0, 1'b1});
        vecs.push_back('{1'b1, 8'h09, 64'd3, 64'd0, 1'b1});
        vecs.push_back('{1'b0, 8'h08, 64'd0, 64'd0, 1'b0});
        vecs.push_back('{1'b1, 8'h18, 64'd5, 64'd0, 1'b0});
        vecs.push_back('{1'b0, 8'h18, 64'd0, 64'd0, 1'b0});
        vecs.push_back('{1'b1, 8'h10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0});
        vecs.push_back('{1'b0, 8'h10, 64'd0, 64'h0000_FFFF_0000_00FF, 1'b0});
        vecs.push_back('{1'b1, 8'h10, 64'd1, 64'd0, 1'b0});
        vecs.push_back('{1'b0, 8'h10, 64'd0, 64'd1, 1'b0});

        foreach (vecs[i]) begin
            bus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er);
            check($sformatf("vec%0d_err", i), 64'(er), 64'(vecs[i].exp_err));
            if (!vecs[i].wr) begin
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            end
        end

        // Channel 1: threshold of 4 with interrupt enabled.
        wr(8'h30, 64'd4);
        wr(8'h28, 64'd1);
        repeat (3) pulse_done(1);
        rd_check("ch1_count3", 8'h38, 64'd3);
        rd_check("ch1_pend_before", 8'h20, 64'd0);
        pulse_done(1);
        check("ch1_irq_lag", 64'(irq_o), 64'd0);
        @(posedge clk_i);
        #1;
        check("ch1_irq_set", 64'(irq_o), 64'b0010);
        rd_check("ch1_pend_done", 8'h20, 64'd1);
        rd_check("ch1_count_clr", 8'h38, 64'd0);
        wr(8'h20, 64'd1);
        check("ch1_irq_clr", 64'(irq_o), 64'd0);
        rd_check("ch1_pend_clr", 8'h20, 64'd0);

        // Channel 2: timeout of 10 cycles after a single completion at edge t.
        wr(8'h50, (64'd10 << 32) | 64'd8);
        pulse_done(2);
        repeat (9) @(posedge clk_i);
        #1;
        rd_check("ch2_pend_t10", 8'h40, 64'd0);
        rd_check("ch2_count_t12", 8'h58, 64'd0);
        rd_check("ch2_pend_t14", 8'h40, 64'd1);
        check("ch2_no_irq", 64'(irq_o), 64'd0);
        wr(8'h40, 64'd1);
        pulse_done(2);
        repeat (10) @(posedge clk_i);
        #1;
        rd_check("ch2_pend_t11", 8'h40, 64'd1);
        wr(8'h40, 64'd1);
        rd_check("ch2_pend_clr", 8'h40, 64'd0);

        // Channel 0: error pulse races a W1C of the ERR bit.
        wr(8'h08, 64'd2);
        err_i[0] = 1'b1;
        fork
            begin
                @(posedge clk_i);
                #1;
                err_i[0] = 1'b0;
            end
        join_none
        wr(8'h00, 64'd2);
        rd_check("ch0_err_kept", 8'h00, 64'd2);
        check("ch0_irq_err", 64'(irq_o), 64'b0001);
        wr(8'h00, 64'd2);
        rd_check("ch0_err_clr", 8'h00, 64'd0);
        check("ch0_irq_clr", 64'(irq_o), 64'd0);

        // Channel 3: lowering THRESH below the current count fires DONE.
        wr(8'h70, 64'd5);
        wr(8'h68, 64'd1);
        repeat (3) pulse_done(3);
        rd_check("ch3_count3", 8'h78, 64'd3);
        rd_check("ch3_pend_before", 8'h60, 64'd0);
        wr(8'h70, 64'd2);
        rd_check("ch3_pend_done", 8'h60, 64'd1);
        rd_check("ch3_count_clr", 8'h78, 64'd0);
        check("ch3_irq_set", 64'(irq_o), 64'b1000);

        // Reset while a read is outstanding: no response, all state cleared.
        reg_valid_i = 1'b1;
        reg_write_i = 1'b0;
        reg_addr_i  = 8'h60;
        rst_i       = 1'b1;
        @(posedge clk_i);
        #1;
        check("rst_req_ready0", 64'(reg_ready_o), 64'd0);
        reg_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("rst_req_ready1", 64'(reg_ready_o), 64'd0);
        check("rst_req_irq", 64'(irq_o), 64'd0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("rst_req_ready2", 64'(reg_ready_o), 64'd0);
        rd_check("rst_ch3_pend", 8'h60, 64'd0);
        rd_check("rst_ch3_enable", 8'h68, 64'd0);
        rd_check("rst_ch1_cfg", 8'h30, 64'd1);
        rd_check("rst_ch2_cfg", 8'h50, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
